multibyte_addsub_seq: RTL and testbench
=======================================

// Module: multibyte_addsub_seq
// PURPOSE
//  Sequencer for multi-byte add/subtract that wraps the 8-bit ripple adder stage. It is upstream
//  (drives add_a/add_b/add_cin) and downstream (consumes add_s/add_cout) of that adder.
//  Takes NUM_BYTES-wide operands over a valid/ready handshake and issues one byte slice per cycle.
//  Chains the carry through a register; returns the full result, carry and signed overflow.
//  Sits between the operand source and the result consumer in the arithmetic datapath.
// PARAMETERS
//  NUM_BYTES  4  operand width in bytes (>=2); full width W = 8*NUM_BYTES
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    operand request valid
//  in_ready   out  1    block can accept operands
//  op_a       in   W    operand A
//  op_b       in   W    operand B
//  op_sub     in   1    1 = A-B, 0 = A+B
//  out_valid  out  1    result valid
//  out_ready  in   1    consumer accepts result
//  res        out  W    sum/difference (mod 2^W)
//  res_cout   out  1    carry out of MSB; in subtract mode 1 = no borrow (A>=B unsigned)
//  res_ovf    out  1    two's-complement signed overflow
//  add_a      out  8    byte slice A to adder
//  add_b      out  8    byte slice B to adder, already inverted when subtracting
//  add_cin    out  1    carry into adder
//  add_s      in   8    adder sum (combinational return)
//  add_cout   in   1    adder carry out (combinational return)
// BEHAVIOUR
//  Reset (async, rst_n low):
//   - state=IDLE; idx, carry, res, res_cout, res_ovf and latched operands all 0.
//   - out_valid=0; in_ready=0 while rst_n low, 1 from first edge after release.
//  FSM IDLE/RUN/DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
//  IDLE:
//   - On in_valid: latch a<=op_a, b<=op_sub ? ~op_b : op_b, carry<=op_sub, sub flag.
//   - Also clear idx and res, then go to RUN.
//  RUN, byte idx:
//   - Adder drive: add_a=a[8*idx+:8], add_b=b[8*idx+:8], add_cin=carry.
//   - Each edge: res[8*idx+:8]<=add_s, carry<=add_cout, idx++.
//   - At idx==NUM_BYTES-1: res_cout<=add_cout, res_ovf<=(a[W-1]==b[W-1]) && (add_s[7]!=a[W-1]), go to DONE.
//  DONE:
//   - res/res_cout/res_ovf held stable until out_ready; on out_ready go to IDLE.
//   - An in_valid in the same cycle is not accepted (in_ready=0); it is taken the next cycle.
//  add_a/add_b/add_cin = 0 outside RUN.
//  Latency: out_valid rises exactly NUM_BYTES edges after the accepting edge.
//   Throughput is one op per NUM_BYTES+2 cycles when out_ready is held high.
//  in_valid/op_* ignored outside IDLE; op_* may change after acceptance.
//  add_s/add_cout sampled only in RUN; adder treated as zero-cycle combinational path.
//  Wrap-around: results are mod 2^W; overflow is reported only via res_cout/res_ovf.
//  Reset mid-RUN/DONE: op aborted immediately, result discarded, no out_valid pulse.
// STRUCTURE
//  Package addsub_seq_pkg: state enum {IDLE,RUN,DONE}; localparam BYTE_W=8.
//  Single module, no internal sub-module; byte-lane mux and idx counter inline.
//  Parent wrapper multibyte_addsub_top instantiates this block plus the 8-bit ripple adder.
// TESTING (NUM_BYTES=4, bench models adder via wrapper)
//  1 add 0x000000FF+0x00000001 -> res 0x00000100, cout 0, ovf 0; out_valid 4 edges after accept
//  2 add 0x7FFFFFFF+0x00000001 -> 0x80000000, cout 0, ovf 1; 0xFFFFFFFF+1 -> 0x0, cout 1, ovf 0
//  3 sub 0x00000005-0x00000007 -> 0xFFFFFFFE, cout 0, ovf 0; sub 0x80000000-1 -> 0x7FFFFFFF, ovf 1
//  4 out_ready=0 for 10 cycles -> out_valid, res stable; in_ready 0; in_valid pulses not accepted
//  5 rst_n low at idx=2 -> out_valid 0 at once, res 0; after release in_ready 1, new op correct
//  6 sub with op_b=0x01020304 -> RUN byte0 shows add_b=0xFB, add_cin=1; byte1 add_b=0xFC

Source files
------------

// File: rtl/addsub_seq_pkg.sv
// Shared types for the multi-byte add/subtract sequencer.
package addsub_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/multibyte_addsub_seq.sv
// Walks a NUM_BYTES-wide add/subtract through an external 8-bit adder, one byte per cycle,
// chaining the carry through a register and reporting carry-out and signed overflow.
module multibyte_addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int NUM_BYTES = 4,
    localparam int W = BYTE_W * NUM_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      op_a,
    input  logic [W-1:0]      op_b,
    input  logic              op_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      res,
    output logic              res_cout,
    output logic              res_ovf,
    output logic [BYTE_W-1:0] add_a,
    output logic [BYTE_W-1:0] add_b,
    output logic              add_cin,
    input  logic [BYTE_W-1:0] add_s,
    input  logic              add_cout
);

    localparam int IDX_W = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [W-1:0]     a_q, b_q, res_q;
    logic             cout_q, ovf_q;
    // Holds in_ready low until the first clock edge after reset release.
    logic             live_q;
    logic             accept;
    logic             last;

    assign in_ready  = (state_q == IDLE) && live_q;
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (idx_q == LAST_IDX);
    assign res       = res_q;
    assign res_cout  = cout_q;
    assign res_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[BYTE_W*idx_q +: BYTE_W];
            add_b   = b_q[BYTE_W*idx_q +: BYTE_W];
            add_cin = carry_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            live_q  <= 1'b1;
            state_q <= state_d;
            case (state_q)
                IDLE: if (accept) begin
                    // Subtract is A + ~B + 1: invert B once here and seed the carry with 1.
                    a_q     <= op_a;
                    b_q     <= op_sub ? ~op_b : op_b;
                    carry_q <= op_sub;
                    idx_q   <= '0;
                    res_q   <= '0;
                end
                RUN: begin
                    res_q[BYTE_W*idx_q +: BYTE_W] <= add_s;
                    carry_q <= add_cout;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last) begin
                        cout_q <= add_cout;
                        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (add_s[BYTE_W-1] != a_q[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multibyte_addsub_seq.sv
// Self-checking bench: byte-adder modelled inline, results checked against a signed/unsigned arithmetic model.
module tb_multibyte_addsub_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, op_sub;
    logic         out_valid, out_ready;
    logic [W-1:0] op_a, op_b, res;
    logic         res_cout, res_ovf;
    logic [7:0]   add_a, add_b, add_s;
    logic         add_cin, add_cout;

    always #5 clk = ~clk;

    // The 8-bit ripple adder the sequencer wraps, as a zero-delay combinational path.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    multibyte_addsub_seq #(.NUM_BYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .res_cout(res_cout), .res_ovf(res_ovf),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_res;
    logic         exp_cout, exp_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain integer arithmetic: wide unsigned for carry/borrow, signed for overflow.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output logic [W-1:0] r, output logic c, output logic o);
        longint ua, ub, sa, sb, sr;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            r  = a - b;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = a + b;
            c  = ((ua + ub) >> 32) != 0;
            sr = sa + sb;
        end
        o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (!exp_valid) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            else begin
                chk("res", 64'(res), 64'(exp_res));
                chk("res_cout", 64'(res_cout), 64'(exp_cout));
                chk("res_ovf", 64'(res_ovf), 64'(exp_ovf));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        wait_ready();
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        op_sub = sub;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        op_sub = 1'($urandom);
        model(a, b, sub, exp_res, exp_cout, exp_ovf);
        exp_valid = 1'b1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input int hold, input bit pulse, input bit lit,
                          input logic [W-1:0] l_res, input logic l_cout, input logic l_ovf);
        logic [W-1:0] bb;
        longint m, ua, ubb;
        logic exp_cin;
        issue(a, b, sub);
        bb  = sub ? ~b : b;
        ua  = longint'({32'b0, a});
        ubb = longint'({32'b0, bb});
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            m = (64'd1 << (8 * k)) - 1;
            exp_cin = 1'(((ua & m) + (ubb & m) + longint'(sub)) >> (8 * k));
            chk("run_out_valid", 64'(out_valid), 64'd0);
            chk("run_in_ready", 64'(in_ready), 64'd0);
            chk($sformatf("add_a[%0d]", k), 64'(add_a), 64'(a[8*k +: 8]));
            chk($sformatf("add_b[%0d]", k), 64'(add_b), 64'(bb[8*k +: 8]));
            chk($sformatf("add_cin[%0d]", k), 64'(add_cin), 64'(exp_cin));
        end
        @(negedge clk);
        chk("latency_out_valid", 64'(out_valid), 64'd1);
        chk("done_add_b", 64'(add_b), 64'd0);
        if (lit) begin
            chk("lit_res", 64'(res), 64'(l_res));
            chk("lit_cout", 64'(res_cout), 64'(l_cout));
            chk("lit_ovf", 64'(res_ovf), 64'(l_ovf));
        end
        for (int h = 0; h < hold; h++) begin
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            if (pulse) begin
                in_valid = 1'($urandom);
                op_a = $urandom;
                op_b = $urandom;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("handoff_out_valid", 64'(out_valid), 64'd0);
        chk("handoff_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic run_abort(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        issue(a, b, sub);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_valid = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_res", 64'(res), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        chk("abort_add_a", 64'(add_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_release_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op_a = '0;
        op_b = '0;
        op_sub = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_cout_ovf", 64'({res_cout, res_ovf}), 64'd0);
        repeat (2) @(negedge clk);
        chk("rst_hold_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        run_op(32'h000000FF, 32'h00000001, 1'b0, 0, 1'b0, 1'b1, 32'h00000100, 1'b0, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
        run_op(32'h00000005, 32'h00000007, 1'b1, 0, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op(32'h80000000, 32'h00000001, 1'b1, 0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        run_op(32'h12345678, 32'h11111111, 1'b0, 10, 1'b1, 1'b1, 32'h23456789, 1'b0, 1'b0);
        run_abort(32'hDEADBEEF, 32'h01010101, 1'b0);
        run_op(32'h11223344, 32'h01020304, 1'b1, 0, 1'b0, 1'b1, 32'h10203040, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)), 1'b1,
                   1'b0, '0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
